// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: edge-latched pending sources, fixed-priority ExtIRQ/ExtIAck/ERet handshake.
// Optional acknowledge timeout enabled by defining IRQ_TIMEOUT_EN.
module ext_irq_ctrl #(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned ID_W    = $clog2(N_SRC),
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             ExtIAck,
  input  logic             ERet,
  output logic             ExtIRQ,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] irq_pending,
  output logic             irq_timeout
);

  if (N_SRC < 2 || N_SRC > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
    $error("ext_irq_ctrl: N_SRC must be 2..16 and TIMEOUT 1..65535");
  end

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state;
  logic [N_SRC-1:0] sync1, sync2, prev, pending;
  logic [N_SRC-1:0] rise, eligible, pend_next;
  logic [ID_W-1:0]  winner;
  logic             any_elig;
  logic             ack_take;

  assign rise        = sync2 & ~prev;
  assign eligible    = pending & irq_mask;
  assign ack_take    = (state == REQ) && ExtIAck;
  assign irq_pending = pending;

  // Lowest set index wins.
  always_comb begin
    winner   = '0;
    any_elig = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (eligible[i] && !any_elig) begin
        winner   = ID_W'(i);
        any_elig = 1'b1;
      end
    end
  end

  // Ack clear first, then new edges OR in so a coincident set wins.
  always_comb begin
    pend_next = pending;
    if (ack_take) pend_next[irq_id] = 1'b0;
    pend_next = pend_next | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      pending <= '0;
    end else begin
      sync1   <= irq_src;
      sync2   <= sync1;
      prev    <= sync2;
      pending <= pend_next;
    end
  end

`ifdef IRQ_TIMEOUT_EN
  logic [15:0] req_cnt;
  logic        timeout_hit;
  logic        timeout_flag;

  assign timeout_hit = (state == REQ) && !ExtIAck && (req_cnt == 16'(TIMEOUT - 1));
  assign irq_timeout = timeout_flag;
`else
  assign irq_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ExtIRQ <= 1'b0;
      irq_id <= '0;
`ifdef IRQ_TIMEOUT_EN
      req_cnt      <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_elig) begin
            irq_id <= winner;
            ExtIRQ <= 1'b1;
            state  <= REQ;
`ifdef IRQ_TIMEOUT_EN
            req_cnt <= '0;
`endif
          end
        end
        REQ: begin
          if (ExtIAck) begin
            ExtIRQ <= 1'b0;
            state  <= SERVICE;
`ifdef IRQ_TIMEOUT_EN
          end else if (timeout_hit) begin
            // Abandon the request; the source stays pending and is re-arbitrated.
            ExtIRQ       <= 1'b0;
            timeout_flag <= 1'b1;
            state        <= IDLE;
          end else begin
            req_cnt <= req_cnt + 16'd1;
`endif
          end
        end
        SERVICE: begin
          if (ERet) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          ExtIRQ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed self-checking bench for ext_irq_ctrl (N_SRC=4, TIMEOUT=8).
module tb_ext_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_src;
  logic [3:0] irq_mask;
  logic       ExtIAck;
  logic       ERet;
  logic       ExtIRQ;
  logic [1:0] irq_id;
  logic [3:0] irq_pending;
  logic       irq_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  ext_irq_ctrl #(.N_SRC(4), .TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_src     (irq_src),
    .irq_mask    (irq_mask),
    .ExtIAck     (ExtIAck),
    .ERet        (ERet),
    .ExtIRQ      (ExtIRQ),
    .irq_id      (irq_id),
    .irq_pending (irq_pending),
    .irq_timeout (irq_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    ExtIAck = 1'b1; tick(); ExtIAck = 1'b0;
  endtask

  task automatic pulse_eret();
    ERet = 1'b1; tick(); ERet = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_src = 4'b0000; irq_mask = 4'b1111; ExtIAck = 1'b0; ERet = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (ExtIRQ !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", ExtIRQ); end
    n_cmp++; if (irq_id !== 2'd0) begin n_bad++; $display("FAIL rst_id: got %0d want 0", irq_id); end
    n_cmp++; if (irq_pending !== 4'b0000) begin n_bad++; $display("FAIL rst_pend: got %b want 0000", irq_pending); end
    n_cmp++; if (irq_timeout !== 1'b0) begin n_bad++; $display("FAIL rst_to: got %b want 0", irq_timeout); end
    tick(2);
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    irq_src = 4'b0100;
    tick(2);
    n_cmp++; if (irq_pending !== 4'b0000) begin n_bad++; $display("FAIL single_pend_e2: got %b want 0000", irq_pending); end
    tick();
    n_cmp++; if (irq_pending !== 4'b0100) begin n_bad++; $display("FAIL single_pend_e3: got %b want 0100", irq_pending); end
    n_cmp++; if (ExtIRQ !== 1'b0) begin n_bad++; $display("FAIL single_irq_e3: got %b want 0", ExtIRQ); end
    tick();
    n_cmp++; if (ExtIRQ !== 1'b1) begin n_bad++; $display("FAIL single_irq_e4: got %b want 1", ExtIRQ); end
    n_cmp++; if (irq_id !== 2'd2) begin n_bad++; $display("FAIL single_id: got %0d want 2", irq_id); end
    pulse_ack();
    n_cmp++; if (ExtIRQ !== 1'b0) begin n_bad++; $display("FAIL single_ack_irq: got %b want 0", ExtIRQ); end
    n_cmp++; if (irq_pending !== 4'b0000) begin n_bad++; $display("FAIL single_ack_pend: got %b want 0000", irq_pending); end
    irq_src = 4'b0000;
    pulse_eret();
    tick(3);
    n_cmp++; if (ExtIRQ !== 1'b0) begin n_bad++; $display("FAIL single_idle_irq: got %b want 0", ExtIRQ); end
  endtask

  task automatic test_back_to_back();
    irq_src = 4'b1010;
    tick(4);
    n_cmp++; if (ExtIRQ !== 1'b1) begin n_bad++; $display("FAIL b2b_irq1: got %b want 1", ExtIRQ); end
    n_cmp++; if (irq_id !== 2'd1) begin n_bad++; $display("FAIL b2b_id1: got %0d want 1", irq_id); end
    n_cmp++; if (irq_pending !== 4'b1010) begin n_bad++; $display("FAIL b2b_pend0: got %b want 1010", irq_pending); end
    pulse_ack();
    n_cmp++; if (irq_pending !== 4'b1000) begin n_bad++; $display("FAIL b2b_pend1: got %b want 1000", irq_pending); end
    pulse_eret();
    n_cmp++; if (ExtIRQ !== 1'b0) begin n_bad++; $display("FAIL b2b_reidle: got %b want 0", ExtIRQ); end
    tick();
    n_cmp++; if (ExtIRQ !== 1'b1) begin n_bad++; $display("FAIL b2b_irq2: got %b want 1", ExtIRQ); end
    n_cmp++; if (irq_id !== 2'd3) begin n_bad++; $display("FAIL b2b_id2: got %0d want 3", irq_id); end
    pulse_ack();
    n_cmp++; if (irq_pending !== 4'b0000) begin n_bad++; $display("FAIL b2b_pend2: got %b want 0000", irq_pending); end
    pulse_eret();
    irq_src = 4'b0000;
    tick(3);
  endtask

  task automatic test_mask();
    irq_mask = 4'b1110;
    irq_src  = 4'b0001;
    tick(4);
    n_cmp++; if (irq_pending !== 4'b0001) begin n_bad++; $display("FAIL mask_pend: got %b want 0001", irq_pending); end
    n_cmp++; if (ExtIRQ !== 1'b0) begin n_bad++; $display("FAIL mask_irq: got %b want 0", ExtIRQ); end
    irq_mask = 4'b1111;
    tick();
    n_cmp++; if (ExtIRQ !== 1'b1) begin n_bad++; $display("FAIL unmask_irq: got %b want 1", ExtIRQ); end
    n_cmp++; if (irq_id !== 2'd0) begin n_bad++; $display("FAIL unmask_id: got %0d want 0", irq_id); end
    // Masking in REQ must not withdraw the request; bit1 edge only sets pending.
    irq_mask = 4'b0000;
    irq_src  = 4'b0011;
    tick(3);
    n_cmp++; if (irq_pending !== 4'b0011) begin n_bad++; $display("FAIL req_pend: got %b want 0011", irq_pending); end
    n_cmp++; if (ExtIRQ !== 1'b1) begin n_bad++; $display("FAIL req_hold_irq: got %b want 1", ExtIRQ); end
    n_cmp++; if (irq_id !== 2'd0) begin n_bad++; $display("FAIL req_hold_id: got %0d want 0", irq_id); end
    irq_mask = 4'b1111;
    ExtIAck = 1'b1; ERet = 1'b1;
    tick();
    ExtIAck = 1'b0; ERet = 1'b0;
    n_cmp++; if (ExtIRQ !== 1'b0) begin n_bad++; $display("FAIL ackeret_irq: got %b want 0", ExtIRQ); end
    n_cmp++; if (irq_pending !== 4'b0010) begin n_bad++; $display("FAIL ackeret_pend: got %b want 0010", irq_pending); end
    tick(2);
    n_cmp++; if (ExtIRQ !== 1'b0) begin n_bad++; $display("FAIL eret_ignored: got %b want 0", ExtIRQ); end
    pulse_ack();
    n_cmp++; if (irq_pending !== 4'b0010) begin n_bad++; $display("FAIL stray_ack_pend: got %b want 0010", irq_pending); end
    pulse_eret();
    tick();
    n_cmp++; if (ExtIRQ !== 1'b1) begin n_bad++; $display("FAIL mask_irq3: got %b want 1", ExtIRQ); end
    n_cmp++; if (irq_id !== 2'd1) begin n_bad++; $display("FAIL mask_id3: got %0d want 1", irq_id); end
    pulse_ack();
    pulse_eret();
    n_cmp++; if (irq_pending !== 4'b0000) begin n_bad++; $display("FAIL mask_pend_end: got %b want 0000", irq_pending); end
    irq_src = 4'b0000;
    tick(3);
  endtask

  task automatic test_service_reraise();
    irq_src = 4'b0100;
    tick(4);
    pulse_ack();
    irq_src = 4'b0000;
    tick(3);
    irq_src = 4'b0100;
    tick(3);
    n_cmp++; if (irq_pending !== 4'b0100) begin n_bad++; $display("FAIL svc_pend: got %b want 0100", irq_pending); end
    n_cmp++; if (ExtIRQ !== 1'b0) begin n_bad++; $display("FAIL svc_irq: got %b want 0", ExtIRQ); end
    pulse_eret();
    tick();
    n_cmp++; if (ExtIRQ !== 1'b1) begin n_bad++; $display("FAIL svc_rereq: got %b want 1", ExtIRQ); end
    n_cmp++; if (irq_id !== 2'd2) begin n_bad++; $display("FAIL svc_id: got %0d want 2", irq_id); end
    // New edge on bit2 lands on the same edge as its ack clear.
    irq_src = 4'b0000;
    tick(3);
    irq_src = 4'b0100;
    tick(2);
    pulse_ack();
    n_cmp++; if (irq_pending !== 4'b0100) begin n_bad++; $display("FAIL setwins_pend: got %b want 0100", irq_pending); end
    n_cmp++; if (ExtIRQ !== 1'b0) begin n_bad++; $display("FAIL setwins_irq: got %b want 0", ExtIRQ); end
    pulse_eret();
    tick();
    n_cmp++; if (ExtIRQ !== 1'b1) begin n_bad++; $display("FAIL setwins_rereq: got %b want 1", ExtIRQ); end
    pulse_ack();
    pulse_eret();
    n_cmp++; if (irq_pending !== 4'b0000) begin n_bad++; $display("FAIL setwins_end: got %b want 0000", irq_pending); end
    irq_src = 4'b0000;
    tick(3);
  endtask

  task automatic test_async_reset();
    irq_src = 4'b1000;
    tick(4);
    n_cmp++; if (irq_id !== 2'd3) begin n_bad++; $display("FAIL ar_pre_id: got %0d want 3", irq_id); end
    irq_src = 4'b0000;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (ExtIRQ !== 1'b0) begin n_bad++; $display("FAIL ar_irq: got %b want 0", ExtIRQ); end
    n_cmp++; if (irq_pending !== 4'b0000) begin n_bad++; $display("FAIL ar_pend: got %b want 0000", irq_pending); end
    n_cmp++; if (irq_id !== 2'd0) begin n_bad++; $display("FAIL ar_id: got %0d want 0", irq_id); end
    tick(2);
    reset = 1'b1;
    tick(3);
    pulse_ack();
    pulse_eret();
    tick();
    n_cmp++; if (ExtIRQ !== 1'b0) begin n_bad++; $display("FAIL stray_irq: got %b want 0", ExtIRQ); end
    n_cmp++; if (irq_pending !== 4'b0000) begin n_bad++; $display("FAIL stray_pend: got %b want 0000", irq_pending); end
  endtask

  task automatic test_timeout();
`ifdef IRQ_TIMEOUT_EN
    irq_src = 4'b0001;
    tick(4);
    n_cmp++; if (ExtIRQ !== 1'b1) begin n_bad++; $display("FAIL to_req: got %b want 1", ExtIRQ); end
    tick(7);
    n_cmp++; if (ExtIRQ !== 1'b1) begin n_bad++; $display("FAIL to_early: got %b want 1", ExtIRQ); end
    tick();
    n_cmp++; if (ExtIRQ !== 1'b0) begin n_bad++; $display("FAIL to_drop: got %b want 0", ExtIRQ); end
    n_cmp++; if (irq_timeout !== 1'b1) begin n_bad++; $display("FAIL to_flag: got %b want 1", irq_timeout); end
    n_cmp++; if (irq_pending !== 4'b0001) begin n_bad++; $display("FAIL to_pend: got %b want 0001", irq_pending); end
    tick();
    n_cmp++; if (ExtIRQ !== 1'b1) begin n_bad++; $display("FAIL to_rereq: got %b want 1", ExtIRQ); end
    pulse_ack();
    pulse_eret();
    n_cmp++; if (irq_timeout !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b want 1", irq_timeout); end
    irq_src = 4'b0000;
    tick(3);
`else
    irq_src = 4'b0001;
    tick(20);
    n_cmp++; if (ExtIRQ !== 1'b1) begin n_bad++; $display("FAIL nto_wait: got %b want 1", ExtIRQ); end
    n_cmp++; if (irq_timeout !== 1'b0) begin n_bad++; $display("FAIL nto_flag: got %b want 0", irq_timeout); end
    pulse_ack();
    pulse_eret();
    irq_src = 4'b0000;
    tick(3);
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_mask();
    test_service_reraise();
    test_async_reset();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
